// File: rtl/scd_pkg.sv
// ---------------------------------------------------------------------------
// scd_pkg
//   Shared definitions for the shift-count/exponent datapath (SCD):
//   datapath widths, SCAD function codes, SCADA/SCADB operand select codes,
//   SC/FE load select codes and small sign-extension helpers.
// ---------------------------------------------------------------------------
package scd_pkg;

    localparam int SC_WIDTH    = 10;
    localparam int SH_MAX      = 36;
    localparam int AR_WIDTH    = 36;
    localparam int MAGIC_WIDTH = 9;
    localparam int ARMM_WIDTH  = 9;
    localparam int SHCNT_WIDTH = 6;

    typedef logic [SC_WIDTH-1:0] sc_word_t;

    // SCAD adder / logic unit function codes
    typedef enum logic [2:0] {
        SCAD_A    = 3'd0,   // A
        SCAD_AMB1 = 3'd1,   // A - B - 1
        SCAD_APB  = 3'd2,   // A + B
        SCAD_AM1  = 3'd3,   // A - 1
        SCAD_AP1  = 3'd4,   // A + 1
        SCAD_AMB  = 3'd5,   // A - B
        SCAD_OR   = 3'd6,   // A | B
        SCAD_AND  = 3'd7    // A & B
    } scad_fn_e;

    // SCADA operand select; codes 4-7 select zero
    typedef enum logic [2:0] {
        SCADA_FE       = 3'd0,
        SCADA_BYTE_POS = 3'd1,
        SCADA_EXP      = 3'd2,
        SCADA_MAGIC    = 3'd3,
        SCADA_ZERO4    = 3'd4,
        SCADA_ZERO5    = 3'd5,
        SCADA_ZERO6    = 3'd6,
        SCADA_ZERO7    = 3'd7
    } scada_sel_e;

    // SCADB operand select
    typedef enum logic [1:0] {
        SCADB_SC        = 2'd0,
        SCADB_BYTE_SIZE = 2'd1,
        SCADB_AR_EXP    = 2'd2,
        SCADB_MAGIC     = 2'd3
    } scadb_sel_e;

    // SC load select
    typedef enum logic [1:0] {
        SC_HOLD     = 2'd0,
        SC_SCAD     = 2'd1,
        SC_AR_SHIFT = 2'd2,
        SC_MAGIC    = 2'd3
    } sc_sel_e;

    // FE load select
    typedef enum logic [1:0] {
        FE_HOLD   = 2'd0,
        FE_SCAD   = 2'd1,
        FE_AR_EXP = 2'd2,
        FE_CLEAR  = 2'd3
    } fe_sel_e;

    // Sign-extend a 9-bit field (microcode literal or AR[0:8]) to SC width.
    function automatic sc_word_t sext9(input logic [8:0] v);
        return {{(SC_WIDTH-9){v[8]}}, v};
    endfunction

    // Zero-extend a 6-bit byte pointer field (position or size) to SC width.
    function automatic sc_word_t zext6(input logic [5:0] v);
        return {{(SC_WIDTH-6){1'b0}}, v};
    endfunction

endpackage

// File: rtl/scd_shift_count_scad_alu.sv
// ---------------------------------------------------------------------------
// scad_alu
//   Combinational SCAD adder/logic unit. All arithmetic is modulo 2^W; the
//   carry-out is intentionally dropped.
//   Ports:
//     a, b    : operands (two's complement)
//     fn      : SCAD function code
//     result  : function result
// ---------------------------------------------------------------------------
module scad_alu
    import scd_pkg::*;
#(
    parameter int W = SC_WIDTH
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  scad_fn_e     fn,
    output logic [W-1:0] result
);

    localparam logic [W-1:0] ONE = W'(1);

    always_comb begin
        result = a;
        case (fn)
            SCAD_A:    result = a;
            SCAD_AMB1: result = a - b - ONE;
            SCAD_APB:  result = a + b;
            SCAD_AM1:  result = a - ONE;
            SCAD_AP1:  result = a + ONE;
            SCAD_AMB:  result = a - b;
            SCAD_OR:   result = a | b;
            SCAD_AND:  result = a & b;
            default:   result = a;
        endcase
    end

endmodule

// File: rtl/scd_shift_count.sv
// ---------------------------------------------------------------------------
// scd_shift_count
//   Shift-count / exponent datapath. Holds the SC loop counter and FE
//   exponent registers, computes SCAD, feeds the shift matrix and the ARMM
//   mixer, and keeps sticky exponent overflow/underflow flags.
//   Bit numbering of EDP_AR follows the EDP convention: bit 0 is the MSB,
//   hence the ascending [0:35] range. SC/FE/SCAD are [W-1:0], so their
//   "bit 0" (sign) is index W-1.
//   Ports:
//     clk, reset           : clock, async active-high reset
//     CRAM_SCAD/SCADA/SCADB: SCAD function and operand selects
//     CRAM_MAGIC           : microcode literal
//     CTL_SC_SEL/FE_SEL    : register load selects
//     CTL_SCstep           : SC decrement (loop step)
//     CTL_ARMM_SEL         : ARMM upper source (0 MAGIC, 1 SCAD)
//     CTL_clrExpFlags      : clear sticky exponent flags
//     EDP_AR               : AR register
//     SCD_*                : register values and derived outputs
// ---------------------------------------------------------------------------
module scd_shift_count
    import scd_pkg::*;
#(
    parameter int SC_W   = SC_WIDTH,
    parameter int SH_LIM = SH_MAX
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             CRAM_SCAD,
    input  logic [2:0]             CRAM_SCADA,
    input  logic [1:0]             CRAM_SCADB,
    input  logic [MAGIC_WIDTH-1:0] CRAM_MAGIC,
    input  logic [1:0]             CTL_SC_SEL,
    input  logic [1:0]             CTL_FE_SEL,
    input  logic                   CTL_SCstep,
    input  logic                   CTL_ARMM_SEL,
    input  logic                   CTL_clrExpFlags,
    input  logic [0:AR_WIDTH-1]    EDP_AR,
    output logic [SC_W-1:0]        SCD_SC,
    output logic [SC_W-1:0]        SCD_FE,
    output logic [SC_W-1:0]        SCD_SCAD,
    output logic                   SCD_SCsign,
    output logic                   SCD_FEsign,
    output logic [SHCNT_WIDTH-1:0] SCD_SHcount,
    output logic                   SCD_SHge36,
    output logic [ARMM_WIDTH-1:0]  SCD_ARMMupper,
    output logic [ARMM_WIDTH-1:0]  SCD_ARMMlower,
    output logic                   SCD_expOverflow,
    output logic                   SCD_expUnderflow
);

    localparam logic [SC_W-1:0] ONE_W    = SC_W'(1);
    localparam logic [SC_W-1:0] SH_LIM_W = SC_W'(SH_LIM);

    // Registers
    logic [SC_W-1:0] sc, sc_next;
    logic [SC_W-1:0] fe, fe_next;
    logic            exp_ovf, exp_ovf_next;
    logic            exp_unf, exp_unf_next;

    // SCAD operands and result
    logic [SC_W-1:0] scad_a;
    logic [SC_W-1:0] scad_b;
    logic [SC_W-1:0] scad;

    // Frequently used AR fields and literals
    logic [SC_W-1:0] magic_sx;
    logic [SC_W-1:0] ar_exp_sx;      // sign-extended AR[0:8]
    logic [SC_W-1:0] ar_exponent;    // float exponent, sign-magnitude corrected
    logic [SC_W-1:0] ar_byte_pos;
    logic [SC_W-1:0] ar_byte_size;
    logic [SC_W-1:0] ar_shift_cnt;   // instruction shift count, sign from AR18
    logic            ar0;

    scada_sel_e scada_sel;
    scadb_sel_e scadb_sel;
    sc_sel_e    sc_sel;
    fe_sel_e    fe_sel;

    logic sh_ge;
    logic ovf_set;
    logic unf_set;

    assign scada_sel = scada_sel_e'(CRAM_SCADA);
    assign scadb_sel = scadb_sel_e'(CRAM_SCADB);
    assign sc_sel    = sc_sel_e'(CTL_SC_SEL);
    assign fe_sel    = fe_sel_e'(CTL_FE_SEL);

    assign ar0          = EDP_AR[0];
    assign magic_sx     = {{(SC_W-MAGIC_WIDTH){CRAM_MAGIC[MAGIC_WIDTH-1]}}, CRAM_MAGIC};
    assign ar_exp_sx    = {{(SC_W-9){EDP_AR[0]}}, EDP_AR[0:8]};
    assign ar_byte_pos  = {{(SC_W-6){1'b0}}, EDP_AR[0:5]};
    assign ar_byte_size = {{(SC_W-6){1'b0}}, EDP_AR[6:11]};
    assign ar_shift_cnt = {{(SC_W-8){EDP_AR[18]}}, EDP_AR[28:35]};

    // Negative floats store the exponent one's-complemented; undo that and
    // extend with the sign so SCAD sees a true two's-complement exponent.
    assign ar_exponent  = {{(SC_W-8){ar0}}, EDP_AR[1:8] ^ {8{ar0}}};

    // -----------------------------------------------------------------------
    // SCAD operand muxes
    // -----------------------------------------------------------------------
    always_comb begin
        scad_a = '0;
        case (scada_sel)
            SCADA_FE:       scad_a = fe;
            SCADA_BYTE_POS: scad_a = ar_byte_pos;
            SCADA_EXP:      scad_a = ar_exponent;
            SCADA_MAGIC:    scad_a = magic_sx;
            default:        scad_a = '0;
        endcase
    end

    always_comb begin
        scad_b = '0;
        case (scadb_sel)
            SCADB_SC:        scad_b = sc;
            SCADB_BYTE_SIZE: scad_b = ar_byte_size;
            SCADB_AR_EXP:    scad_b = ar_exp_sx;
            SCADB_MAGIC:     scad_b = magic_sx;
            default:         scad_b = '0;
        endcase
    end

    scad_alu #(
        .W (SC_W)
    ) u_scad_alu (
        .a      (scad_a),
        .b      (scad_b),
        .fn     (scad_fn_e'(CRAM_SCAD)),
        .result (scad)
    );

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // Any load outranks the loop step; the step decrement wraps 0 -> -1.
    always_comb begin
        sc_next = sc;
        case (sc_sel)
            SC_SCAD:     sc_next = scad;
            SC_AR_SHIFT: sc_next = ar_shift_cnt;
            SC_MAGIC:    sc_next = magic_sx;
            default: begin
                if (CTL_SCstep) begin
                    sc_next = sc - ONE_W;
                end
            end
        endcase
    end

    always_comb begin
        fe_next = fe;
        case (fe_sel)
            FE_SCAD:   fe_next = scad;
            FE_AR_EXP: fe_next = ar_exp_sx;
            FE_CLEAR:  fe_next = '0;
            default:   fe_next = fe;
        endcase
    end

    // The two top SCAD bits disagreeing means the 10-bit exponent left the
    // 9-bit signed range: 01 is above +255, 10 is below -256.
    assign ovf_set = (fe_sel == FE_SCAD) && !scad[SC_W-1] &&  scad[SC_W-2];
    assign unf_set = (fe_sel == FE_SCAD) &&  scad[SC_W-1] && !scad[SC_W-2];

    // A new event in the clearing cycle must not be lost, so set wins.
    assign exp_ovf_next = ovf_set | (exp_ovf & ~CTL_clrExpFlags);
    assign exp_unf_next = unf_set | (exp_unf & ~CTL_clrExpFlags);

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sc      <= '0;
            fe      <= '0;
            exp_ovf <= 1'b0;
            exp_unf <= 1'b0;
        end else begin
            sc      <= sc_next;
            fe      <= fe_next;
            exp_ovf <= exp_ovf_next;
            exp_unf <= exp_unf_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // A negative SC means "no shift left to do", so it saturates like a
    // large count and the shift matrix is told to shift by zero.
    assign sh_ge = sc[SC_W-1] | (sc >= SH_LIM_W);

    assign SCD_SC           = sc;
    assign SCD_FE           = fe;
    assign SCD_SCAD         = scad;
    assign SCD_SCsign       = sc[SC_W-1];
    assign SCD_FEsign       = fe[SC_W-1];
    assign SCD_SHge36       = sh_ge;
    assign SCD_SHcount      = sh_ge ? '0 : sc[SHCNT_WIDTH-1:0];
    assign SCD_ARMMupper    = CTL_ARMM_SEL ? scad[ARMM_WIDTH-1:0] : CRAM_MAGIC;
    assign SCD_ARMMlower    = sc[ARMM_WIDTH-1:0];
    assign SCD_expOverflow  = exp_ovf;
    assign SCD_expUnderflow = exp_unf;

endmodule
